// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch-state encoding and instruction constants.
`default_nettype none

package cpu_pkg;

  localparam int PC_W   = 8;
  localparam int INSN_W = 16;

  localparam logic [15:0] NOP_CODE = 16'h0000;

  // Halt is recognised by opcode field [15:12] == 0 with bit 9 set.
  localparam logic [3:0]  HLT_OPCODE = 4'b0000;
  localparam int          HLT_BIT    = 9;
  localparam logic [15:0] HLT_CODE   = 16'h0200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  function automatic logic is_hlt(input logic [15:0] word);
    return (word[15:12] == HLT_OPCODE) && word[HLT_BIT];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack sequencing, registered code word to the decoder,
// jump redirects (with drain of an outstanding request) and a sticky halt.
`default_nettype none

module fetch_unit #(
  parameter int                      PC_W     = cpu_pkg::PC_W,
  parameter int                      INSN_W   = cpu_pkg::INSN_W,
  parameter logic [cpu_pkg::PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [INSN_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  input  logic              flag_hlt,
  input  logic              jmp_taken,
  input  logic [PC_W-1:0]   jmp_target,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  import cpu_pkg::*;

  fetch_state_e      state, state_d;
  logic [PC_W-1:0]   pc_d;
  logic [PC_W-1:0]   req_addr, req_addr_d;
  logic [INSN_W-1:0] code_d;
  logic              valid_d;
  logic              halted_d;
  logic              accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= PC_W'(RESET_PC);
      req_addr   <= PC_W'(RESET_PC);
      code       <= INSN_W'(NOP_CODE);
      code_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      pc         <= pc_d;
      req_addr   <= req_addr_d;
      code       <= code_d;
      code_valid <= valid_d;
      halted     <= halted_d;
    end
  end

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    req_addr_d = req_addr;
    code_d     = code;
    valid_d    = code_valid;
    halted_d   = halted;
    accept     = code_valid & code_ready;

    case (state)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (jmp_taken) begin
          pc_d    = jmp_target;
          valid_d = 1'b0;
          if (imem_ack) begin
            state_d = ST_FETCH;
          end else begin
            // Request still in flight: remember its address so it stays stable until the ack.
            state_d    = ST_DRAIN;
            req_addr_d = pc;
          end
        end else if (imem_ack) begin
          code_d  = imem_rdata;
          valid_d = 1'b1;
          pc_d    = pc + PC_W'(1);
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (accept && flag_hlt) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (jmp_taken) begin
          pc_d    = jmp_target;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end else if (accept) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (jmp_taken) begin
          pc_d = jmp_target;
        end
        if (imem_ack) begin
          state_d = ST_FETCH;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
  assign imem_addr = (state == ST_DRAIN) ? req_addr : pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] code;
  logic        code_valid;
  logic        code_ready;
  logic        flag_hlt;
  logic        jmp_taken;
  logic [7:0]  jmp_target;
  logic [7:0]  pc;
  logic        halted;

  int   lat;
  int   cnt;
  logic use_hlt;
  int   n_checks;
  int   n_pass;

  fetch_unit #(.PC_W(8), .INSN_W(16), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .flag_hlt   (flag_hlt),
    .jmp_taken  (jmp_taken),
    .jmp_target (jmp_target),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after lat waiting cycles (lat=0 acks in the request cycle), word = addr | 8000.
  assign imem_ack   = imem_req && (cnt == lat);
  assign imem_rdata = use_hlt ? 16'h0200 : {8'h80, imem_addr};

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    lat        = 0;
    use_hlt    = 1'b0;
    code_ready = 1'b1;
    flag_hlt   = 1'b0;
    jmp_taken  = 1'b0;
    jmp_target = 8'h00;

    #12;
    chk("rst_pc", pc, 8'h00);
    chk("rst_code", code, 16'h0000);
    chk("rst_valid", code_valid, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    tick();

    // Sequential fetch with zero-wait memory, one word every two cycles
    for (int i = 0; i < 3; i++) begin
      chk("seq_req", imem_req, 1'b1);
      chk("seq_addr", imem_addr, i);
      tick();
      chk("seq_valid", code_valid, 1'b1);
      chk("seq_code", code, 16'h8000 | i);
      chk("seq_pc", pc, i + 1);
      tick();
    end

    // Same-cycle ack and jump: word dropped
    jmp_taken  = 1'b1;
    jmp_target = 8'h10;
    tick();
    jmp_taken = 1'b0;
    chk("jack_valid", code_valid, 1'b0);
    chk("jack_addr", imem_addr, 8'h10);
    chk("jack_pc", pc, 8'h10);
    chk("jack_code_kept", code, 16'h8002);
    chk("jack_req", imem_req, 1'b1);

    // Downstream stall
    code_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_code", code, 16'h8010);
      chk("stall_valid", code_valid, 1'b1);
      chk("stall_req", imem_req, 1'b0);
      tick();
    end
    code_ready = 1'b1;
    tick();
    chk("unstall_valid", code_valid, 1'b0);
    chk("unstall_addr", imem_addr, 8'h11);
    tick();
    chk("unstall_code", code, 16'h8011);
    chk("unstall_pc", pc, 8'h12);

    // Jump in ISSUE to FF, then PC wrap
    code_ready = 1'b0;
    jmp_taken  = 1'b1;
    jmp_target = 8'hFF;
    tick();
    jmp_taken = 1'b0;
    chk("jiss_valid", code_valid, 1'b0);
    chk("jiss_addr", imem_addr, 8'hFF);
    tick();
    chk("wrap_code", code, 16'h80FF);
    chk("wrap_pc", pc, 8'h00);

    // Jump while a slow fetch is outstanding -> drain
    lat        = 3;
    code_ready = 1'b1;
    tick();
    chk("slow_addr", imem_addr, 8'h00);
    chk("slow_noack", imem_ack, 1'b0);
    jmp_taken  = 1'b1;
    jmp_target = 8'h40;
    tick();
    jmp_taken = 1'b0;
    chk("drain_req", imem_req, 1'b1);
    chk("drain_addr", imem_addr, 8'h00);
    chk("drain_pc", pc, 8'h40);
    tick();
    tick();
    chk("drain_ack", imem_ack, 1'b1);
    chk("drain_addr_held", imem_addr, 8'h00);
    tick();
    chk("postdrain_addr", imem_addr, 8'h40);
    chk("postdrain_valid", code_valid, 1'b0);
    chk("postdrain_code", code, 16'h80FF);
    lat = 0;
    tick();
    chk("j40_code", code, 16'h8040);
    chk("j40_pc", pc, 8'h41);
    tick();
    chk("j40_next_addr", imem_addr, 8'h41);

    // Halt: unaccepted flag ignored, accepted flag wins over jump
    use_hlt = 1'b1;
    tick();
    use_hlt = 1'b0;
    chk("hlt_code", code, 16'h0200);
    chk("hlt_pc", pc, 8'h42);
    code_ready = 1'b0;
    flag_hlt   = 1'b1;
    tick();
    chk("hlt_noacc_halted", halted, 1'b0);
    chk("hlt_noacc_valid", code_valid, 1'b1);
    code_ready = 1'b1;
    jmp_taken  = 1'b1;
    jmp_target = 8'h77;
    tick();
    jmp_target = 8'h55;
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_valid", code_valid, 1'b0);
    chk("hlt_req", imem_req, 1'b0);
    chk("hlt_pc", pc, 8'h42);
    repeat (3) tick();
    chk("hlt_stay_halted", halted, 1'b1);
    chk("hlt_stay_req", imem_req, 1'b0);
    chk("hlt_stay_pc", pc, 8'h42);
    jmp_taken = 1'b0;
    flag_hlt  = 1'b0;

    // Asynchronous reset out of halt
    rst = 1'b1;
    #1;
    chk("rst2_pc", pc, 8'h00);
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_req", imem_req, 1'b0);
    chk("rst2_code", code, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst2_fetch_req", imem_req, 1'b1);
    chk("rst2_fetch_addr", imem_addr, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
